btb_update_sched: RTL
=====================

// Module: btb_update_sched
// PURPOSE
//  Collects resolved JALR target updates from execution-side requesters and schedules them into the
//  static predictor's single BTB update port (btb_update_i/pc_i/target_i).
//  Round-robin admits up to NREQ requesters into a small coalescing queue.
//  Drains one entry per unstalled cycle through a registered output stage.
//  Sits between EXU/commit and sbpu; the sbpu only samples its update port when any_stall_i is low.
// PARAMETERS
//  ADDR_W   32  instruction address width (= `INST_ADDR_WIDTH)
//  NREQ     2   number of update requesters (e.g. EXU pipe0, EXU pipe1)
//  QDEPTH   4   queue entries; power of 2, >=2
// PORTS
//  clk                  in   1              clock
//  rst_n                in   1              asynchronous reset, active-low
//  req_valid_i          in   NREQ           requester r has an update
//  req_pc_i             in   NREQ*ADDR_W    JALR PC, requester r at [r*ADDR_W +: ADDR_W]
//  req_target_i         in   NREQ*ADDR_W    resolved target, same packing
//  req_ready_o          out  NREQ           request r accepted this cycle (comb grant)
//  any_stall_i          in   1              pipeline stall; output not consumed while high
//  flush_i              in   1              discard all pending updates (fence.i / ITCM rewrite)
//  btb_update_o         out  1              update valid to sbpu btb_update_i
//  btb_update_pc_o      out  ADDR_W         to sbpu btb_update_pc_i
//  btb_update_target_o  out  ADDR_W         to sbpu btb_update_target_i
//  q_count_o            out  $clog2(QDEPTH)+1  occupancy of the queue (excluding the output stage)
// BEHAVIOUR
//  Reset: btb_update_o=0; pc_o/target_o=0; q_count_o=0; queue empty; RR pointer=0; req_ready_o=0.
//  Arbitration:
//   - One grant per cycle, round-robin starting at rr_ptr.
//   - rr_ptr <= granted+1 (mod NREQ) on grant; it does not move without a grant.
//   - req_ready_o[r]=1 only for the granted r.
//   - A request must hold valid/pc/target until it sees ready.
//  Admission: the granted entry is admitted if any of:
//   (a) Coalescing: its PC equals a valid queued entry that is NOT being popped this cycle.
//       That entry's target is overwritten in place and count is unchanged; allowed even when full.
//   (b) The queue is not full.
//   (c) The queue is full and a pop occurs this cycle; a simultaneous push+pop at full is legal.
//  Otherwise no grant is issued this cycle.
//  Match against the entry being popped does not coalesce; the request is pushed as a new entry.
//  Output stage (out_v/out_pc/out_tgt registers drive the outputs):
//   - consume = out_v & ~any_stall_i.
//   - Pop the queue head into the stage when (~out_v | consume) and the queue is non-empty.
//   - Stage holds its value unchanged while any_stall_i=1, so no update is lost to the sbpu stall gating.
//   - Bypass: if the queue is empty and the stage is free, the granted request loads the stage directly.
//     Latency: accept in cycle N -> btb_update_o=1 in N+1. Coalescing never targets the stage.
//  Order: FIFO in admission order; pointers wrap mod QDEPTH; count = wr-rd with the extra wrap bit.
//  flush_i (priority over everything):
//   - Next cycle: queue empty, out_v=0, count=0.
//   - req_ready_o=0 during the flush cycle.
//   - rr_ptr is kept.
//  Async reset mid-drain: all state cleared immediately, with no partial update emitted afterwards.
//  Widths: comparisons are full ADDR_W (no partial tags); targets are not range-checked here.
// STRUCTURE
//  Shared defines/package:
//   - typedef struct packed {logic [ADDR_W-1:0] pc, target;} btb_upd_t.
//   - `BTB_UPD_QDEPTH and `BTB_UPD_NREQ defaults.
//  Sub-module rr_arbiter #(N) (req, en, grant one-hot, ptr update); reused later for other arbitration.
//  Queue storage, CAM match and output stage are inline in this module.
// TESTING
//  1 Single: req0 pc=0x80000100 tgt=0x80000400, no stall.
//    -> ready0 in cycle 0; btb_update_o=1 in cycle 1 with those values; idle in cycle 2.
//  2 Contention: req0 and req1 valid together for 4 cycles (distinct PCs).
//    -> grants alternate 0,1,0,1; output order matches the grant order.
//  3 Stall hold: output valid, any_stall_i=1 for 3 cycles.
//    -> pc/target stable, q_count_o unchanged; consumed on the first stall-low cycle.
//  4 Full + coalesce: fill 4 entries (pc 0x..10,0x..20,0x..30,0x..40) under stall.
//    -> new pc 0x..50: no ready.
//    -> pc 0x..30 tgt 0x..999: ready, count stays 4; the drained 3rd update carries 0x..999.
//  5 Full push+pop: queue full, stall drops while a new request is valid.
//    -> ready the same cycle, count stays 4, order preserved.
//  6 Flush/reset: flush_i with 3 queued entries plus a valid stage.
//    -> next cycle btb_update_o=0, count=0.
//    -> Async rst_n pulse mid-drain: outputs go to 0 immediately.

Source files
------------

// File: rtl/btb_update_sched_pkg.sv
// Shared types and default sizing for the BTB update scheduler and its requesters.
// Pure declarations, no logic.
package btb_update_sched_pkg;

    localparam int BTB_UPD_ADDR_W = 32;
    localparam int BTB_UPD_NREQ   = 2;
    localparam int BTB_UPD_QDEPTH = 4;

    typedef struct packed {
        logic [BTB_UPD_ADDR_W-1:0] pc;
        logic [BTB_UPD_ADDR_W-1:0] target;
    } btb_upd_t;

endpackage

// File: rtl/btb_update_sched_if.sv
// Requester-side and sbpu-side signals of the BTB update scheduler.
// master drives requests/stall/flush, slave is the scheduler.
interface btb_update_sched_if
    import btb_update_sched_pkg::*;
#(
    parameter int ADDR_W = BTB_UPD_ADDR_W,
    parameter int NREQ   = BTB_UPD_NREQ,
    parameter int QDEPTH = BTB_UPD_QDEPTH
);
    localparam int CW = $clog2(QDEPTH) + 1;

    logic [NREQ-1:0]        req_valid_i;
    logic [NREQ*ADDR_W-1:0] req_pc_i;
    logic [NREQ*ADDR_W-1:0] req_target_i;
    logic [NREQ-1:0]        req_ready_o;
    logic                   any_stall_i;
    logic                   flush_i;
    logic                   btb_update_o;
    logic [ADDR_W-1:0]      btb_update_pc_o;
    logic [ADDR_W-1:0]      btb_update_target_o;
    logic [CW-1:0]          q_count_o;

    modport master (
        output req_valid_i, req_pc_i, req_target_i, any_stall_i, flush_i,
        input  req_ready_o, btb_update_o, btb_update_pc_o, btb_update_target_o, q_count_o
    );

    modport slave (
        input  req_valid_i, req_pc_i, req_target_i, any_stall_i, flush_i,
        output req_ready_o, btb_update_o, btb_update_pc_o, btb_update_target_o, q_count_o
    );

endinterface

// File: rtl/btb_update_sched_rr_arbiter.sv
// Round-robin arbiter: combinational candidate/grant, pointer moves past the winner only when en grants.
// Zero latency; a withheld en (backpressure) issues no grant and leaves the pointer in place.
module rr_arbiter #(
    parameter  int N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  i_req,
    input  logic          i_en,
    output logic          o_cand_vld,
    output logic [IW-1:0] o_cand_idx,
    output logic [N-1:0]  o_grant
);
    localparam int IW1 = IW + 1;

    logic [IW-1:0]  r_ptr;
    logic [2*N-1:0] w_dbl;
    logic [N-1:0]   w_rot;
    logic [IW-1:0]  w_off;
    logic [IW:0]    w_sum;

    // w_rot[i] is the request sitting i places after the pointer
    assign w_dbl = {i_req, i_req} >> r_ptr;
    assign w_rot = w_dbl[N-1:0];

    always_comb begin
        o_cand_vld = 1'b0;
        w_off      = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                o_cand_vld = 1'b1;
                w_off      = IW'(i);
            end
        end
        w_sum      = {1'b0, r_ptr} + {1'b0, w_off};
        o_cand_idx = (w_sum >= IW1'(N)) ? IW'(w_sum - IW1'(N)) : w_sum[IW-1:0];
    end

    assign o_grant = (i_en && o_cand_vld) ? (N'(1) << o_cand_idx) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (i_en && o_cand_vld) begin
            r_ptr <= (o_cand_idx == IW'(N - 1)) ? '0 : o_cand_idx + IW'(1);
        end
    end

endmodule

// File: rtl/btb_update_sched.sv
// Schedules JALR target updates into the single sbpu BTB port via a coalescing FIFO; accept -> update 1 cycle later.
// Output holds under any_stall_i; requesters see no ready when the queue is full and nothing drains or coalesces.
module btb_update_sched
    import btb_update_sched_pkg::*;
#(
    parameter int ADDR_W = BTB_UPD_ADDR_W,
    parameter int NREQ   = BTB_UPD_NREQ,
    parameter int QDEPTH = BTB_UPD_QDEPTH
) (
    input logic               clk,
    input logic               rst_n,
    btb_update_sched_if.slave bus
);
    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [ADDR_W-1:0] target;
    } upd_t;

    upd_t          r_mem [QDEPTH];
    logic [CW-1:0] r_wr;
    logic [CW-1:0] r_rd;
    logic          r_out_v;
    upd_t          r_out;

    logic [CW-1:0]     w_count;
    logic              w_empty;
    logic              w_full;
    logic              w_consume;
    logic              w_stage_free;
    logic              w_pop;
    logic              w_cand_vld;
    logic [IW-1:0]     w_cand_idx;
    logic [NREQ-1:0]   w_grant;
    upd_t              w_cand;
    logic [QDEPTH-1:0] w_match;
    logic              w_hit;
    logic [AW-1:0]     w_hit_idx;
    logic              w_admit;
    logic              w_bypass;
    logic              w_push;
    logic              w_coal;

    assign w_count      = r_wr - r_rd;
    assign w_empty      = (w_count == '0);
    assign w_full       = (w_count == CW'(QDEPTH));
    assign w_consume    = r_out_v & ~bus.any_stall_i;
    assign w_stage_free = ~r_out_v | w_consume;
    assign w_pop        = ~bus.flush_i & ~w_empty & w_stage_free;

    rr_arbiter #(.N(NREQ)) u_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_req      (bus.req_valid_i),
        .i_en       (w_admit),
        .o_cand_vld (w_cand_vld),
        .o_cand_idx (w_cand_idx),
        .o_grant    (w_grant)
    );

    assign w_cand.pc     = bus.req_pc_i[int'(w_cand_idx) * ADDR_W +: ADDR_W];
    assign w_cand.target = bus.req_target_i[int'(w_cand_idx) * ADDR_W +: ADDR_W];

    // Live entries only; the head leaving this cycle is excluded so its update is not lost
    for (genvar k = 0; k < QDEPTH; k++) begin : g_cam
        logic [AW-1:0] w_off;
        assign w_off      = AW'(k) - r_rd[AW-1:0];
        assign w_match[k] = ({1'b0, w_off} < w_count)
                          && !(w_pop && (AW'(k) == r_rd[AW-1:0]))
                          && (r_mem[k].pc == w_cand.pc);
    end

    always_comb begin
        w_hit_idx = '0;
        for (int k = 0; k < QDEPTH; k++) begin
            if (w_match[k]) w_hit_idx = AW'(k);
        end
    end

    assign w_hit    = |w_match;
    assign w_admit  = w_cand_vld & ~bus.flush_i & (w_hit | ~w_full | w_pop);
    assign w_bypass = w_admit & w_empty & w_stage_free;
    assign w_push   = w_admit & ~w_hit & ~w_bypass;
    assign w_coal   = w_admit & w_hit;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr[AW-1:0]] <= w_cand;
        end else if (w_coal) begin
            r_mem[w_hit_idx].target <= w_cand.target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_out_v <= 1'b0;
            r_out   <= '0;
        end else if (bus.flush_i) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_out_v <= 1'b0;
        end else begin
            if (w_push) r_wr <= r_wr + CW'(1);
            if (w_pop) begin
                r_rd    <= r_rd + CW'(1);
                r_out_v <= 1'b1;
                r_out   <= r_mem[r_rd[AW-1:0]];
            end else if (w_bypass) begin
                r_out_v <= 1'b1;
                r_out   <= w_cand;
            end else if (w_consume) begin
                r_out_v <= 1'b0;
            end
        end
    end

    assign bus.req_ready_o         = w_grant;
    assign bus.btb_update_o        = r_out_v;
    assign bus.btb_update_pc_o     = r_out.pc;
    assign bus.btb_update_target_o = r_out.target;
    assign bus.q_count_o           = w_count;

endmodule
